multicycle_controller: RTL and testbench
========================================

// Module: multicycle_controller
// PURPOSE
//  FSM sequencing the multicycle RV32I datapath over one shared instruction/data memory.
//  Per state, drives datapath mux selects and write enables, plus a req/ready memory handshake.
//  Resolves branch conditions from ALU flags and counts retired instructions.
//  Sits beside the datapath; ImmSrc and ALU control come from op/funct3 each cycle.
// PARAMETERS
//  WAIT_LIMIT  0   max cycles to wait for mem_ready; 0 = wait forever; N>0 -> TRAP after N
//  CNT_W       32  width of retired-instruction counter
// PORTS
//  clk         in   1      single clock, rising edge
//  rst_n       in   1      asynchronous, active-low reset
//  op          in   7      instr[6:0] from IR
//  funct3      in   3      instr[14:12] from IR
//  Zero,ALUR31,carry in 1  ALU flags (equal, signed-lt, unsigned-lt) for current ALU op
//  mem_ready   in   1      memory completes the access on this edge
//  mem_req     out  1      memory access requested (FETCH, MEMREAD, MEMWRITE)
//  MemWrite    out  1      store; level, held with mem_req
//  AdrSrc      out  1      0 = PC, 1 = ALUOut
//  IRWrite     out  1      latch IR and OldPC
//  PCWrite     out  1      PC <= Result
//  RegWrite    out  1      register file write
//  ResultSrc   out  2      00 ALUOut, 01 Data, 10 ALUResult, 11 ImmExt
//  ALUSrcA     out  2      00 PC, 01 OldPC, 10 RD1
//  ALUSrcB     out  2      00 RD2, 01 ImmExt, 10 const 4
//  ALUOp       out  2      00 add, 01 sub/compare, 10 funct-decoded
//  ImmSrc      out  3      from op: 000 I, 001 S, 010 B, 011 J, 100 U
//  instr_done  out  1      1-cycle pulse, last cycle of an instruction
//  retired     out  CNT_W  retired-instruction count, wraps modulo 2^CNT_W
//  bus_err     out  1      sticky; set on entering TRAP
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=FETCH, counters=0, bus_err=0. Outputs are decoded from state, so FETCH values apply.
//  - Unlisted controls = 0 (ResultSrc/ALUSrc/ALUOp default 00).
//  - FETCH: mem_req, A=00, B=10, ResultSrc=10. On mem_ready: IRWrite, PCWrite -> DECODE.
//  - DECODE: A=01, B=01 (ALUOut<=OldPC+imm). Next state by op:
//    lw/sw->MEMADR, R->EXECR, I-ALU->EXECI, branch->BRANCH, jal->JAL,
//    jalr->JALR, lui->LUI, auipc->ALUWB, any other op->TRAP.
//  - MEMADR: A=10, B=01. lw->MEMREAD; sw->MEMWRITE.
//  - MEMREAD: mem_req, AdrSrc=1. Wait for ready -> MEMWB.
//  - MEMWB: ResultSrc=01, RegWrite -> FETCH.
//  - MEMWRITE: mem_req, AdrSrc=1, MemWrite. Wait for ready -> FETCH.
//  - EXECR: A=10, B=00, ALUOp=10. EXECI: A=10, B=01, ALUOp=10. Both -> ALUWB.
//  - ALUWB: ResultSrc=00, RegWrite -> FETCH.
//  - BRANCH: A=10, B=00, ALUOp=01, ResultSrc=00, PCWrite=take -> FETCH.
//    take: beq Zero, bne !Zero, blt ALUR31, bge !ALUR31, bltu carry, bgeu !carry.
//    funct3 010/011 -> take=0.
//  - JAL: A=01, B=10, ResultSrc=00, PCWrite -> ALUWB (rd<=OldPC+4).
//  - JALR: A=10, B=01, ResultSrc=10, PCWrite -> LINK. The datapath clears target bit 0.
//  - LINK: A=01, B=10 -> ALUWB.
//  - LUI: ResultSrc=11, RegWrite -> FETCH.
//  - Wait states (FETCH/MEMREAD/MEMWRITE): hold all outputs while mem_ready=0.
//    Wait counter clears on state entry and on ready.
//    If WAIT_LIMIT>0 and the counter reaches WAIT_LIMIT with ready still 0 -> TRAP.
//    Ready arriving in the limit cycle wins: normal transition.
//  - TRAP: absorbing until reset; bus_err=1; mem_req=0 and all write enables 0.
//  - instr_done = 1 on any transition into FETCH (not from reset).
//    retired increments on the same edge; all-ones wraps to 0.
//  - Reset mid-access: mem_req drops asynchronously; no partial writes retained by controller.
//  - CPI: lw 5, sw 4, R/I 4, branch 3, jal 4, jalr 5, lui 3, auipc 3 (zero wait states).
// STRUCTURE
//  - Shared header riscv_defs.vh: opcode localparams, state encodings (4-bit), ResultSrc/ALUSrc/ImmSrc codes.
//  - Sub-module branch_cond (funct3, Zero, ALUR31, carry -> take), combinational.
//  - Body: state register, next-state case, output case, wait counter, retire counter.
// TESTING
//  1. Reset 3 cycles, ready=1, add -> states FETCH,DECODE,EXECR,ALUWB; RegWrite only in ALUWB; retired=1.
//  2. lw with mem_ready low 2 cycles in MEMREAD -> 7 cycles total; mem_req, AdrSrc=1 held stable.
//  3. beq Zero=1 -> PCWrite=1 in BRANCH; bne Zero=1 -> PCWrite=0; bgeu carry=0 -> PCWrite=1.
//  4. jalr -> JALR asserts PCWrite with ResultSrc=10; LINK then ALUWB writes rd; 5 cycles total.
//  5. WAIT_LIMIT=4, ready never -> TRAP after 4 FETCH wait cycles, bus_err=1, no enables.
//     Ready in cycle 4 -> no trap.
//  6. op=0000000 -> TRAP. CNT_W=4, 16 retirements -> retired wraps to 0.
//     rst_n low mid-MEMWRITE -> MemWrite=0 immediately, FETCH.

Source files
------------

// File: rtl/multicycle_controller_pkg.sv
// Shared definitions for the multicycle RV32I controller: opcodes, state
// encoding and datapath select codes.
package multicycle_controller_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_JALR     = 4'd11,
        S_LINK     = 4'd12,
        S_LUI      = 4'd13,
        S_TRAP     = 4'd14
    } state_e;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;
    localparam logic [1:0] RES_IMMEXT    = 2'b11;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    // Immediate format is a pure function of the opcode in the IR.
    function automatic logic [2:0] imm_src_for(input logic [6:0] op);
        logic [2:0] imm;
        case (op)
            OP_STORE:          imm = IMM_S;
            OP_BRANCH:         imm = IMM_B;
            OP_JAL:            imm = IMM_J;
            OP_LUI, OP_AUIPC:  imm = IMM_U;
            default:           imm = IMM_I;
        endcase
        return imm;
    endfunction

    // States that hold a memory request open until mem_ready.
    function automatic logic is_wait_state(input state_e s);
        return (s == S_FETCH) || (s == S_MEMREAD) || (s == S_MEMWRITE);
    endfunction

endpackage

// File: rtl/multicycle_controller_branch_cond.sv
// Branch resolution from ALU flags of the compare (subtract) in BRANCH.
module multicycle_controller_branch_cond (
    input  logic [2:0] funct3_i,
    input  logic       zero_i,
    input  logic       lt_i,
    input  logic       ltu_i,
    output logic       take_o
);

    // funct3 selects which flag (or its inverse) decides the branch.
    always_comb begin
        take_o = 1'b0;
        case (funct3_i)
            3'b000:  take_o = zero_i;
            3'b001:  take_o = ~zero_i;
            3'b100:  take_o = lt_i;
            3'b101:  take_o = ~lt_i;
            3'b110:  take_o = ltu_i;
            3'b111:  take_o = ~ltu_i;
            default: take_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RV32I controller: sequences the shared-memory datapath, waits on
// the memory handshake (optionally bounded), resolves branches and counts
// retired instructions.
//
// state    | meaning
// FETCH    | read instruction at PC, PC <= PC+4 on ready
// DECODE   | ALUOut <= OldPC + imm, dispatch on opcode
// MEMADR   | ALUOut <= RD1 + imm (load/store address)
// MEMREAD  | load access at ALUOut
// MEMWB    | rd <= Data
// MEMWRITE | store access at ALUOut
// EXECR    | ALUOut <= RD1 op RD2
// EXECI    | ALUOut <= RD1 op imm
// ALUWB    | rd <= ALUOut
// BRANCH   | compare RD1/RD2, PC <= ALUOut if taken
// JAL      | PC <= ALUOut (target), ALUOut <= OldPC+4
// JALR     | PC <= RD1 + imm
// LINK     | ALUOut <= OldPC+4
// LUI      | rd <= ImmExt
// TRAP     | illegal opcode or memory timeout; held until reset
module multicycle_controller
    import multicycle_controller_pkg::*;
#(
    parameter int unsigned WAIT_LIMIT = 0,
    parameter int unsigned CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       op,
    input  logic [2:0]       funct3,
    input  logic             Zero,
    input  logic             ALUR31,
    input  logic             carry,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             MemWrite,
    output logic             AdrSrc,
    output logic             IRWrite,
    output logic             PCWrite,
    output logic             RegWrite,
    output logic [1:0]       ResultSrc,
    output logic [1:0]       ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic [2:0]       ImmSrc,
    output logic             instr_done,
    output logic [CNT_W-1:0] retired,
    output logic             bus_err
);

    // Wait timer is a down-counter reloaded with WAIT_LIMIT-1; reaching zero
    // with ready still low marks the final permitted wait cycle.
    localparam int unsigned WCNT_W = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT) : 1;
    localparam logic [WCNT_W-1:0] WCNT_LOAD =
        (WAIT_LIMIT > 0) ? WCNT_W'(WAIT_LIMIT - 1) : '0;

    state_e             state_q, state_d;
    logic [WCNT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0]   retired_q, retired_d;
    logic               bus_err_q, bus_err_d;
    logic               take;
    logic               in_wait;
    logic               wait_expired;

    multicycle_controller_branch_cond u_branch_cond (
        .funct3_i (funct3),
        .zero_i   (Zero),
        .lt_i     (ALUR31),
        .ltu_i    (carry),
        .take_o   (take)
    );

    assign in_wait      = is_wait_state(state_q);
    assign wait_expired = (WAIT_LIMIT > 0) && in_wait && !mem_ready && (wait_cnt_q == '0);

    // Next-state selection; a wait timeout overrides everything else.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:    if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_REG:            state_d = S_EXECR;
                    OP_IMM:            state_d = S_EXECI;
                    OP_BRANCH:         state_d = S_BRANCH;
                    OP_JAL:            state_d = S_JAL;
                    OP_JALR:           state_d = S_JALR;
                    OP_LUI:            state_d = S_LUI;
                    OP_AUIPC:          state_d = S_ALUWB;
                    default:           state_d = S_TRAP;
                endcase
            end
            S_MEMADR:   state_d = (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  if (mem_ready) state_d = S_MEMWB;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: if (mem_ready) state_d = S_FETCH;
            S_EXECR,
            S_EXECI:    state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_BRANCH:   state_d = S_FETCH;
            S_JAL:      state_d = S_ALUWB;
            S_JALR:     state_d = S_LINK;
            S_LINK:     state_d = S_ALUWB;
            S_LUI:      state_d = S_FETCH;
            S_TRAP:     state_d = S_TRAP;
            default:    state_d = S_TRAP;
        endcase
        if (wait_expired) state_d = S_TRAP;
    end

    // Datapath controls decoded from the current state; IR/PC latch on ready.
    always_comb begin
        mem_req   = 1'b0;
        MemWrite  = 1'b0;
        AdrSrc    = 1'b0;
        IRWrite   = 1'b0;
        PCWrite   = 1'b0;
        RegWrite  = 1'b0;
        ResultSrc = RES_ALUOUT;
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_RD2;
        ALUOp     = ALUOP_ADD;
        case (state_q)
            S_FETCH: begin
                mem_req   = 1'b1;
                ALUSrcA   = SRCA_PC;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
                IRWrite   = mem_ready;
                PCWrite   = mem_ready;
            end
            S_DECODE: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
            end
            S_MEMADR: begin
                ALUSrcA = SRCA_RD1;
                ALUSrcB = SRCB_IMM;
            end
            S_MEMREAD: begin
                mem_req = 1'b1;
                AdrSrc  = 1'b1;
            end
            S_MEMWB: begin
                ResultSrc = RES_DATA;
                RegWrite  = 1'b1;
            end
            S_MEMWRITE: begin
                mem_req  = 1'b1;
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
            end
            S_EXECR: begin
                ALUSrcA = SRCA_RD1;
                ALUSrcB = SRCB_RD2;
                ALUOp   = ALUOP_FUNCT;
            end
            S_EXECI: begin
                ALUSrcA = SRCA_RD1;
                ALUSrcB = SRCB_IMM;
                ALUOp   = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                ResultSrc = RES_ALUOUT;
                RegWrite  = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA   = SRCA_RD1;
                ALUSrcB   = SRCB_RD2;
                ALUOp     = ALUOP_SUB;
                ResultSrc = RES_ALUOUT;
                PCWrite   = take;
            end
            S_JAL: begin
                ALUSrcA   = SRCA_OLDPC;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALUOUT;
                PCWrite   = 1'b1;
            end
            S_JALR: begin
                ALUSrcA   = SRCA_RD1;
                ALUSrcB   = SRCB_IMM;
                ResultSrc = RES_ALURESULT;
                PCWrite   = 1'b1;
            end
            S_LINK: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_FOUR;
            end
            S_LUI: begin
                ResultSrc = RES_IMMEXT;
                RegWrite  = 1'b1;
            end
            default: ;
        endcase
    end

    assign ImmSrc     = imm_src_for(op);
    assign instr_done = (state_d == S_FETCH) && (state_q != S_FETCH);

    // Counter and sticky-error next values.
    always_comb begin
        wait_cnt_d = WCNT_LOAD;
        if (in_wait && !mem_ready && (wait_cnt_q != '0)) wait_cnt_d = wait_cnt_q - 1'b1;
        retired_d = retired_q;
        if (instr_done) retired_d = retired_q + CNT_W'(1);
        bus_err_d = bus_err_q | (state_d == S_TRAP);
    end

    // State register; reset lands in FETCH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    // Wait timer, retire counter and sticky bus error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_q <= WCNT_LOAD;
            retired_q  <= '0;
            bus_err_q  <= 1'b0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            retired_q  <= retired_d;
            bus_err_q  <= bus_err_d;
        end
    end

    assign retired = retired_q;
    assign bus_err = bus_err_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench: dut0 (unbounded wait, 32-bit count) runs a table of
// instructions through a control-word scoreboard; dut1 (WAIT_LIMIT=4, 4-bit
// count) covers timeout, illegal opcode and counter wrap.
module tb_multicycle_controller;

    localparam logic [6:0] T_LW = 7'b0000011, T_SW = 7'b0100011, T_R = 7'b0110011,
                           T_I = 7'b0010011, T_BR = 7'b1100011, T_JAL = 7'b1101111,
                           T_JALR = 7'b1100111, T_LUI = 7'b0110111, T_AUIPC = 7'b0010111;

    typedef enum int {B_FETCH, B_DECODE, B_MEMADR, B_MEMREAD, B_MEMWB, B_MEMWRITE,
                      B_EXECR, B_EXECI, B_ALUWB, B_BRANCH, B_JAL, B_JALR, B_LINK,
                      B_LUI, B_NONE} bst_e;

    typedef struct {
        logic [6:0] op;
        logic [2:0] f3;
        logic       z, r31, c, take;
        logic [2:0] imm;
        logic [6:0] rdy;
        int         n;
        bst_e       st[7];
    } vec_t;

    typedef struct {
        logic [17:0] w;
        int          row;
        int          cyc;
    } exp_t;

    logic clk;
    logic rst_n, rst1_n;
    logic [6:0] op, op1;
    logic [2:0] funct3;
    logic zero, alur31, carry, mem_ready, ready1;

    logic mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, instr_done, bus_err;
    logic [1:0] result_src, alu_src_a, alu_src_b, alu_op;
    logic [2:0] imm_src;
    logic [31:0] retired;

    logic mem_req1, mem_write1, adr_src1, ir_write1, pc_write1, reg_write1, instr_done1, bus_err1;
    logic [1:0] result_src1, alu_src_a1, alu_src_b1, alu_op1;
    logic [2:0] imm_src1;
    logic [3:0] retired1;

    logic [17:0] word0, word1;
    assign word0 = {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
                    result_src, alu_src_a, alu_src_b, alu_op, imm_src, instr_done};
    assign word1 = {mem_req1, mem_write1, adr_src1, ir_write1, pc_write1, reg_write1,
                    result_src1, alu_src_a1, alu_src_b1, alu_op1, imm_src1, instr_done1};

    int n_tests = 0;
    int n_fail  = 0;
    int exp_retired = 0;
    vec_t vecs[$];
    exp_t sb[$];

    multicycle_controller #(.WAIT_LIMIT(0), .CNT_W(32)) dut0 (
        .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .Zero(zero),
        .ALUR31(alur31), .carry(carry), .mem_ready(mem_ready), .mem_req(mem_req),
        .MemWrite(mem_write), .AdrSrc(adr_src), .IRWrite(ir_write), .PCWrite(pc_write),
        .RegWrite(reg_write), .ResultSrc(result_src), .ALUSrcA(alu_src_a),
        .ALUSrcB(alu_src_b), .ALUOp(alu_op), .ImmSrc(imm_src), .instr_done(instr_done),
        .retired(retired), .bus_err(bus_err)
    );

    multicycle_controller #(.WAIT_LIMIT(4), .CNT_W(4)) dut1 (
        .clk(clk), .rst_n(rst1_n), .op(op1), .funct3(funct3), .Zero(zero),
        .ALUR31(alur31), .carry(carry), .mem_ready(ready1), .mem_req(mem_req1),
        .MemWrite(mem_write1), .AdrSrc(adr_src1), .IRWrite(ir_write1), .PCWrite(pc_write1),
        .RegWrite(reg_write1), .ResultSrc(result_src1), .ALUSrcA(alu_src_a1),
        .ALUSrcB(alu_src_b1), .ALUOp(alu_op1), .ImmSrc(imm_src1), .instr_done(instr_done1),
        .retired(retired1), .bus_err(bus_err1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Expected control word for one state, built from the controller's state table.
    function automatic logic [17:0] exp_word(input bst_e s, input logic take, input logic rdy,
                                             input logic [2:0] imm, input logic last);
        logic req, mw, adr, irw, pcw, rw;
        logic [1:0] rs, a, b, aop;
        req = 0; mw = 0; adr = 0; irw = 0; pcw = 0; rw = 0;
        rs = 2'b00; a = 2'b00; b = 2'b00; aop = 2'b00;
        case (s)
            B_FETCH:    begin req = 1; a = 2'b00; b = 2'b10; rs = 2'b10; irw = rdy; pcw = rdy; end
            B_DECODE:   begin a = 2'b01; b = 2'b01; end
            B_MEMADR:   begin a = 2'b10; b = 2'b01; end
            B_MEMREAD:  begin req = 1; adr = 1; end
            B_MEMWB:    begin rs = 2'b01; rw = 1; end
            B_MEMWRITE: begin req = 1; adr = 1; mw = 1; end
            B_EXECR:    begin a = 2'b10; b = 2'b00; aop = 2'b10; end
            B_EXECI:    begin a = 2'b10; b = 2'b01; aop = 2'b10; end
            B_ALUWB:    begin rs = 2'b00; rw = 1; end
            B_BRANCH:   begin a = 2'b10; b = 2'b00; aop = 2'b01; pcw = take; end
            B_JAL:      begin a = 2'b01; b = 2'b10; pcw = 1; end
            B_JALR:     begin a = 2'b10; b = 2'b01; rs = 2'b10; pcw = 1; end
            B_LINK:     begin a = 2'b01; b = 2'b10; end
            B_LUI:      begin rs = 2'b11; rw = 1; end
            default: ;
        endcase
        return {req, mw, adr, irw, pcw, rw, rs, a, b, aop, imm, last};
    endfunction

    function automatic vec_t mk(input logic [6:0] o, input logic [2:0] f3, input logic z,
                                input logic r31, input logic c, input logic take,
                                input logic [2:0] imm, input logic [6:0] rdy, input int n,
                                input bst_e s0, input bst_e s1, input bst_e s2, input bst_e s3,
                                input bst_e s4, input bst_e s5, input bst_e s6);
        vec_t v;
        v.op = o; v.f3 = f3; v.z = z; v.r31 = r31; v.c = c; v.take = take;
        v.imm = imm; v.rdy = rdy; v.n = n;
        v.st[0] = s0; v.st[1] = s1; v.st[2] = s2; v.st[3] = s3;
        v.st[4] = s4; v.st[5] = s5; v.st[6] = s6;
        return v;
    endfunction

    task automatic compare_pop();
        exp_t e;
        if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard_empty: got output with no expectation queued");
        end else begin
            e = sb.pop_front();
            n_tests++;
            if (word0 !== e.w) begin
                n_fail++;
                $display("FAIL ctl row %0d cyc %0d: got %b expected %b", e.row, e.cyc, word0, e.w);
            end
        end
    endtask

    task automatic run_row(input int r);
        vec_t v;
        exp_t e;
        v = vecs[r];
        op = v.op; funct3 = v.f3; zero = v.z; alur31 = v.r31; carry = v.c;
        for (int i = 0; i < v.n; i++) begin
            mem_ready = v.rdy[i];
            e.w   = exp_word(v.st[i], v.take, v.rdy[i], v.imm, i == v.n - 1);
            e.row = r;
            e.cyc = i;
            sb.push_back(e);
            @(negedge clk);
            compare_pop();
            @(posedge clk); #1;
        end
        exp_retired++;
        check($sformatf("retired row %0d", r), 64'(retired), 64'(exp_retired));
    endtask

    task automatic pulse_rst1();
        rst1_n = 1'b0;
        #2;
        rst1_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; rst1_n = 1'b0;
        op = T_R; op1 = T_R; funct3 = 3'b000;
        zero = 0; alur31 = 0; carry = 0; mem_ready = 0; ready1 = 0;

        //                  op      f3      z  r  c  tk imm     rdy       n  states
        vecs.push_back(mk(T_R,     3'b000, 0, 0, 0, 0, 3'b000, 7'h7f, 4, B_FETCH, B_DECODE, B_EXECR, B_ALUWB, B_NONE, B_NONE, B_NONE));
        vecs.push_back(mk(T_I,     3'b000, 0, 0, 0, 0, 3'b000, 7'h7f, 4, B_FETCH, B_DECODE, B_EXECI, B_ALUWB, B_NONE, B_NONE, B_NONE));
        vecs.push_back(mk(T_LW,    3'b010, 0, 0, 0, 0, 3'b000, 7'h7f, 5, B_FETCH, B_DECODE, B_MEMADR, B_MEMREAD, B_MEMWB, B_NONE, B_NONE));
        vecs.push_back(mk(T_SW,    3'b010, 0, 0, 0, 0, 3'b001, 7'h7f, 4, B_FETCH, B_DECODE, B_MEMADR, B_MEMWRITE, B_NONE, B_NONE, B_NONE));
        vecs.push_back(mk(T_BR,    3'b000, 1, 0, 0, 1, 3'b010, 7'h7f, 3, B_FETCH, B_DECODE, B_BRANCH, B_NONE, B_NONE, B_NONE, B_NONE));
        vecs.push_back(mk(T_BR,    3'b001, 1, 0, 0, 0, 3'b010, 7'h7f, 3, B_FETCH, B_DECODE, B_BRANCH, B_NONE, B_NONE, B_NONE, B_NONE));
        vecs.push_back(mk(T_BR,    3'b111, 0, 0, 0, 1, 3'b010, 7'h7f, 3, B_FETCH, B_DECODE, B_BRANCH, B_NONE, B_NONE, B_NONE, B_NONE));
        vecs.push_back(mk(T_BR,    3'b100, 0, 1, 0, 1, 3'b010, 7'h7f, 3, B_FETCH, B_DECODE, B_BRANCH, B_NONE, B_NONE, B_NONE, B_NONE));
        vecs.push_back(mk(T_BR,    3'b101, 0, 1, 0, 0, 3'b010, 7'h7f, 3, B_FETCH, B_DECODE, B_BRANCH, B_NONE, B_NONE, B_NONE, B_NONE));
        vecs.push_back(mk(T_BR,    3'b110, 0, 0, 1, 1, 3'b010, 7'h7f, 3, B_FETCH, B_DECODE, B_BRANCH, B_NONE, B_NONE, B_NONE, B_NONE));
        vecs.push_back(mk(T_BR,    3'b010, 1, 1, 1, 0, 3'b010, 7'h7f, 3, B_FETCH, B_DECODE, B_BRANCH, B_NONE, B_NONE, B_NONE, B_NONE));
        vecs.push_back(mk(T_BR,    3'b000, 0, 0, 0, 0, 3'b010, 7'h7f, 3, B_FETCH, B_DECODE, B_BRANCH, B_NONE, B_NONE, B_NONE, B_NONE));
        vecs.push_back(mk(T_JAL,   3'b000, 0, 0, 0, 0, 3'b011, 7'h7f, 4, B_FETCH, B_DECODE, B_JAL, B_ALUWB, B_NONE, B_NONE, B_NONE));
        vecs.push_back(mk(T_JALR,  3'b000, 0, 0, 0, 0, 3'b000, 7'h7f, 5, B_FETCH, B_DECODE, B_JALR, B_LINK, B_ALUWB, B_NONE, B_NONE));
        vecs.push_back(mk(T_LUI,   3'b000, 0, 0, 0, 0, 3'b100, 7'h7f, 3, B_FETCH, B_DECODE, B_LUI, B_NONE, B_NONE, B_NONE, B_NONE));
        vecs.push_back(mk(T_AUIPC, 3'b000, 0, 0, 0, 0, 3'b100, 7'h7f, 3, B_FETCH, B_DECODE, B_ALUWB, B_NONE, B_NONE, B_NONE, B_NONE));
        vecs.push_back(mk(T_LW,    3'b010, 0, 0, 0, 0, 3'b000, 7'b1100111, 7, B_FETCH, B_DECODE, B_MEMADR, B_MEMREAD, B_MEMREAD, B_MEMREAD, B_MEMWB));
        vecs.push_back(mk(T_SW,    3'b010, 0, 0, 0, 0, 3'b001, 7'b1011100, 7, B_FETCH, B_FETCH, B_FETCH, B_DECODE, B_MEMADR, B_MEMWRITE, B_MEMWRITE));
        vecs.push_back(mk(T_BR,    3'b101, 0, 0, 0, 1, 3'b010, 7'h7f, 3, B_FETCH, B_DECODE, B_BRANCH, B_NONE, B_NONE, B_NONE, B_NONE));

        // Reset state of dut0: FETCH controls with ready low, counters clear.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_ctl", 64'(word0), 64'(exp_word(B_FETCH, 1'b0, 1'b0, 3'b000, 1'b0)));
        check("reset_retired", 64'(retired), 64'd0);
        check("reset_bus_err", 64'(bus_err), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int r = 0; r < vecs.size(); r++) run_row(r);
        check("table_bus_err", 64'(bus_err), 64'd0);
        check("sb_drained", 64'(sb.size()), 64'd0);

        // Reset in the middle of a stalled store.
        op = T_SW; funct3 = 3'b010; mem_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        mem_ready = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check("sw_memwrite_held", 64'(mem_write), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_memwrite", 64'(mem_write), 64'd0);
        check("rst_mid_adrsrc", 64'(adr_src), 64'd0);
        check("rst_mid_retired", 64'(retired), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // dut1: no ready ever -> 4 FETCH wait cycles then TRAP.
        zero = 0; alur31 = 0; carry = 0; funct3 = 3'b000;
        op1 = T_R; ready1 = 1'b0;
        @(posedge clk); #1;
        rst1_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("wl_fetch_req c%0d", i), 64'(mem_req1), 64'd1);
            check($sformatf("wl_no_err c%0d", i), 64'(bus_err1), 64'd0);
            @(posedge clk); #1;
        end
        @(negedge clk);
        check("wl_trap_bus_err", 64'(bus_err1), 64'd1);
        check("wl_trap_ctl", 64'(word1), 64'd0);
        ready1 = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("trap_absorbing", 64'({bus_err1, mem_req1}), 64'b10);

        // dut1: ready in the 4th wait cycle of FETCH and of MEMREAD -> no trap.
        @(posedge clk); #1;
        op1 = T_LW; ready1 = 1'b0;
        pulse_rst1();
        check("rst_clears_bus_err", 64'(bus_err1), 64'd0);
        repeat (3) begin @(posedge clk); #1; end
        ready1 = 1'b1;
        @(negedge clk);
        check("wl_ready_c4_irwrite", 64'(ir_write1), 64'd1);
        @(posedge clk); #1;
        ready1 = 1'b0;
        @(negedge clk);
        check("wl_ready_c4_decode", 64'({bus_err1, mem_req1}), 64'b00);
        @(posedge clk); #1;
        @(posedge clk); #1;
        repeat (3) begin @(posedge clk); #1; end
        ready1 = 1'b1;
        @(negedge clk);
        check("wl_memread_c4", 64'({mem_req1, adr_src1, bus_err1}), 64'b110);
        @(posedge clk); #1;
        @(negedge clk);
        check("wl_memwb_regwrite", 64'(reg_write1), 64'd1);
        @(posedge clk); #1;
        check("wl_lw_retired", 64'(retired1), 64'd1);
        check("wl_lw_no_err", 64'(bus_err1), 64'd0);

        // dut1: illegal opcode traps out of DECODE.
        op1 = 7'b0000000; ready1 = 1'b1;
        pulse_rst1();
        @(posedge clk); #1;
        @(negedge clk);
        check("illegal_decode_no_err", 64'(bus_err1), 64'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("illegal_trap_err", 64'(bus_err1), 64'd1);
        check("illegal_trap_req", 64'(mem_req1), 64'd0);
        check("illegal_retired", 64'(retired1), 64'd0);

        // dut1: 16 LUI retirements wrap the 4-bit counter to zero.
        @(posedge clk); #1;
        op1 = T_LUI; ready1 = 1'b1;
        pulse_rst1();
        for (int k = 0; k < 16; k++) begin
            @(posedge clk); #1;
            @(posedge clk); #1;
            @(negedge clk);
            check($sformatf("lui_done k%0d", k), 64'(instr_done1), 64'd1);
            @(posedge clk); #1;
            check($sformatf("wrap_retired k%0d", k), 64'(retired1), 64'((k + 1) % 16));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
